// File: rtl/systolic_result_drain.sv
// Result drain for an N x N systolic array: freezes the PEs, shifts results down,
// captures the N rows leaving the bottom edge and returns them row by row.
module systolic_result_drain #(
    parameter int N          = 4,
    parameter int INT_WIDTH  = 8,
    parameter int FRAC_WIDTH = 8,
    localparam int W         = INT_WIDTH + FRAC_WIDTH,
    localparam int RW        = $clog2(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_val,
    output logic            start_rdy,
    output logic            shift_result,
    output logic            array_finished,
    output logic            feed_zero,
    input  logic [N*W-1:0]  col_in,
    output logic            resp_val,
    input  logic            resp_rdy,
    output logic [N*W-1:0]  resp_msg,
    output logic [RW-1:0]   resp_row,
    output logic [1:0]      dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHIFT   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_EMIT    = 2'd3;

    localparam logic [RW-1:0] LAST = RW'(N - 1);

    logic [1:0]     state;
    logic [RW-1:0]  cap_cnt;
    logic [RW-1:0]  row_ptr;
    logic [N*W-1:0] buffer [N];

    // Both interfaces are val/rdy: a transfer happens on any posedge where val
    // and rdy are both high; the producer holds val and payload until then.
    wire start_fire = start_val && (state == ST_IDLE);
    wire resp_fire  = resp_rdy && (state == ST_EMIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cap_cnt <= '0;
            row_ptr <= '0;
            for (int i = 0; i < N; i++) begin
                buffer[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_fire) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    cap_cnt <= '0;
                    state   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    // The bottom row leaves the array first, so fill from the end.
                    buffer[LAST - cap_cnt] <= col_in;
                    cap_cnt <= cap_cnt + RW'(1);
                    if (cap_cnt == LAST) begin
                        cap_cnt <= '0;
                        row_ptr <= '0;
                        state   <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (resp_fire) begin
                        if (row_ptr == LAST) begin
                            row_ptr <= '0;
                            state   <= ST_IDLE;
                        end else begin
                            row_ptr <= row_ptr + RW'(1);
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign start_rdy      = (state == ST_IDLE);
    assign shift_result   = (state == ST_SHIFT);
    assign array_finished = (state == ST_SHIFT) || (state == ST_CAPTURE);
    assign feed_zero      = (state == ST_SHIFT) || (state == ST_CAPTURE);
    assign resp_val       = (state == ST_EMIT);
    assign resp_msg       = (state == ST_EMIT) ? buffer[row_ptr] : '0;
    assign resp_row       = row_ptr;
    assign dbg_state      = state;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain (N=4, W=16): drain timing, column
// mapping, backpressure, held start, mid-capture reset and control envelope.
module tb_systolic_result_drain;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int RW = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            start_val;
    logic            start_rdy;
    logic            shift_result;
    logic            array_finished;
    logic            feed_zero;
    logic [N*W-1:0]  col_in;
    logic            resp_val;
    logic            resp_rdy;
    logic [N*W-1:0]  resp_msg;
    logic [RW-1:0]   resp_row;
    logic [1:0]      dbg_state;

    logic [N*W-1:0]  mat [N];
    int n_cmp = 0;
    int n_bad = 0;

    systolic_result_drain #(.N(N), .INT_WIDTH(8), .FRAC_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .start_val(start_val), .start_rdy(start_rdy),
        .shift_result(shift_result), .array_finished(array_finished),
        .feed_zero(feed_zero), .col_in(col_in),
        .resp_val(resp_val), .resp_rdy(resp_rdy),
        .resp_msg(resp_msg), .resp_row(resp_row), .dbg_state(dbg_state)
    );

    // ---- clock / reset ----
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---- driver tasks ----
    task automatic load_replicated();
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                mat[r][j*W +: W] = W'(16'h0100 * (r + 1));
    endtask

    task automatic load_colmap(input int base);
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                mat[r][j*W +: W] = W'(((r + base) << 8) | j);
    endtask

    // One full drain; rows are expected to come back exactly as mat[0..N-1].
    task automatic drain(input int bp_row, input int bp_len, input bit hold);
        int k;
        start_val = 1'b1;
        k = 0;
        while (!start_rdy && k < 100) begin
            tick();
            k++;
        end
        n_cmp++;
        if (start_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL start_wait: start_rdy=%b required 1", start_rdy);
        end
        tick();
        if (!hold) start_val = 1'b0;
        n_cmp++;
        if (shift_result !== 1'b1 || start_rdy !== 1'b0 || array_finished !== 1'b1 ||
            feed_zero !== 1'b1 || resp_val !== 1'b0) begin
            n_bad++;
            $display("FAIL shift: shift=%b rdy=%b fin=%b fz=%b val=%b required 1 0 1 1 0",
                     shift_result, start_rdy, array_finished, feed_zero, resp_val);
        end
        for (int c = 0; c < N; c++) begin
            tick();
            col_in = mat[N-1-c];
            n_cmp++;
            if (shift_result !== 1'b0 || start_rdy !== 1'b0 || array_finished !== 1'b1 ||
                feed_zero !== 1'b1 || resp_val !== 1'b0) begin
                n_bad++;
                $display("FAIL capture%0d: shift=%b rdy=%b fin=%b fz=%b val=%b required 0 0 1 1 0",
                         c, shift_result, start_rdy, array_finished, feed_zero, resp_val);
            end
        end
        tick();
        col_in = {$urandom, $urandom};
        for (int r = 0; r < N; r++) begin
            if (r == bp_row) begin
                resp_rdy = 1'b0;
                for (int b = 0; b < bp_len; b++) begin
                    n_cmp++;
                    if (resp_val !== 1'b1 || resp_msg !== mat[r] || resp_row !== RW'(r) ||
                        start_rdy !== 1'b0) begin
                        n_bad++;
                        $display("FAIL stall_row%0d: val=%b row=%0d msg=%h rdy=%b required 1 %0d %h 0",
                                 r, resp_val, resp_row, resp_msg, start_rdy, r, mat[r]);
                    end
                    tick();
                end
            end
            resp_rdy = 1'b1;
            n_cmp++;
            if (resp_val !== 1'b1 || resp_msg !== mat[r] || resp_row !== RW'(r) ||
                start_rdy !== 1'b0 || array_finished !== 1'b0 || feed_zero !== 1'b0) begin
                n_bad++;
                $display("FAIL emit_row%0d: val=%b row=%0d msg=%h rdy=%b fin=%b fz=%b required 1 %0d %h 0 0 0",
                         r, resp_val, resp_row, resp_msg, start_rdy, array_finished, feed_zero,
                         r, mat[r]);
            end
            tick();
        end
        n_cmp++;
        if (start_rdy !== 1'b1 || resp_val !== 1'b0 || array_finished !== 1'b0 ||
            feed_zero !== 1'b0 || shift_result !== 1'b0 || resp_msg !== '0) begin
            n_bad++;
            $display("FAIL back_idle: rdy=%b val=%b fin=%b fz=%b shift=%b msg=%h required 1 0 0 0 0 0",
                     start_rdy, resp_val, array_finished, feed_zero, shift_result, resp_msg);
        end
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (start_rdy !== 1'b1 || shift_result !== 1'b0 || array_finished !== 1'b0 ||
            feed_zero !== 1'b0 || resp_val !== 1'b0 || resp_msg !== '0 || resp_row !== '0) begin
            n_bad++;
            $display("FAIL reset: rdy=%b shift=%b fin=%b fz=%b val=%b msg=%h row=%0d required 1 0 0 0 0 0 0",
                     start_rdy, shift_result, array_finished, feed_zero, resp_val, resp_msg, resp_row);
        end
        reset = 1'b0;
        // No start: block must sit in IDLE.
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (start_rdy !== 1'b1 || shift_result !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_hold: rdy=%b shift=%b required 1 0", start_rdy, shift_result);
        end
    endtask

    task automatic test_basic();
        load_replicated();
        resp_rdy = 1'b1;
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_column_map();
        load_colmap(0);
        drain(-1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        load_colmap(4);
        drain(1, 5, 1'b0);
    endtask

    task automatic test_back_to_back();
        load_colmap(8);
        drain(-1, 0, 1'b1);
        load_replicated();
        drain(2, 2, 1'b1);
        start_val = 1'b0;
        tick();
        n_cmp++;
        if (start_rdy !== 1'b1 || shift_result !== 1'b0) begin
            n_bad++;
            $display("FAIL start_release: rdy=%b shift=%b required 1 0", start_rdy, shift_result);
        end
    endtask

    task automatic test_reset_mid_capture();
        load_colmap(12);
        start_val = 1'b1;
        tick();
        start_val = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            col_in = mat[N-1-c];
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (start_rdy !== 1'b1 || shift_result !== 1'b0 || array_finished !== 1'b0 ||
            feed_zero !== 1'b0 || resp_val !== 1'b0 || resp_msg !== '0 || resp_row !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: rdy=%b shift=%b fin=%b fz=%b val=%b msg=%h row=%0d required 1 0 0 0 0 0 0",
                     start_rdy, shift_result, array_finished, feed_zero, resp_val, resp_msg, resp_row);
        end
        load_colmap(7);
        drain(0, 1, 1'b0);
    endtask

    // ---- sequence and report ----
    initial begin
        reset     = 1'b1;
        start_val = 1'b0;
        resp_rdy  = 1'b0;
        col_in    = '0;
        test_reset();
        test_basic();
        test_column_map();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/systolic_result_drain.md
Name: systolic_result_drain

Overview:
Result-side controller and collector for an N x N systolic multiply array of fixed-point PEs. Once the feeder has pushed all operands, it accepts a start request, freezes PE accumulation, issues the one-cycle shift_result pulse that moves each PE's result into its pass-down register, and captures the N result rows as they exit the bottom edge. The captured matrix is then returned row by row on a val/rdy response interface. The block sits between the bottom row of the array and the accelerator's response path.

Parameters:
N, 4, array dimension (rows = columns); N >= 2
INT_WIDTH, 8, integer bits of fixed-point word
FRAC_WIDTH, 8, fractional bits; W = INT_WIDTH+FRAC_WIDTH

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
start_val  input  1  feeder signals operand streaming complete; drain requested
start_rdy  output  1  drain idle and able to accept start
shift_result  output  1  broadcast to array; loads each PE result into its pass-down register
array_finished  output  1  drives PE finished inputs; holds accumulators
feed_zero  output  1  instructs feeder to drive 0 on all top a and left b edges
col_in  input  N*W  bottom-row pass-down outputs; column j at bits [j*W +: W]
resp_val  output  1  result row valid
resp_rdy  input  1  consumer accepts row
resp_msg  output  N*W  result row; column j at bits [j*W +: W]
resp_row  output  clog2(N)  index of row currently on resp_msg

Behaviour:
- Reset: state IDLE; start_rdy=1; shift_result=0; array_finished=0; feed_zero=0; resp_val=0; resp_msg=0; resp_row=0; row buffer and counters cleared. All outputs registered or decoded from registered state only; no combinational path from any input to any output.
- FSM states IDLE, SHIFT, CAPTURE, EMIT.
- IDLE: start_rdy=1. Transfer occurs on start_val && start_rdy. Move to SHIFT next cycle. No transfer means the block stays in IDLE.
- SHIFT: lasts exactly 1 cycle. shift_result=1, array_finished=1, feed_zero=1, start_rdy=0. Move to CAPTURE with cap_cnt=0.
- CAPTURE: lasts exactly N cycles. shift_result=0, array_finished=1, feed_zero=1.
  - On each cycle, col_in is written to buffer[N-1-cap_cnt]. The bottom row exits first and row 0 exits last, after N-1 hops down the a-path.
  - cap_cnt increments each cycle. After the cycle with cap_cnt=N-1, move to EMIT.
  - col_in is ignored in every state except CAPTURE.
- EMIT: array_finished=0, feed_zero=0, resp_val=1, resp_msg=buffer[row_ptr], resp_row=row_ptr. row_ptr starts at 0.
  - On resp_val && resp_rdy, row_ptr increments.
  - When row N-1 is accepted, move to IDLE. start_rdy=1 in the following cycle.
  - resp_msg and resp_row stay stable while resp_val=1 and resp_rdy=0. Indefinite backpressure is legal, with no loss and no reorder.
- Latency: start handshake at cycle t -> shift_result high at t+1 -> captures at t+2..t+N+1 -> first resp_val at t+N+2.
- Start is ignored (start_rdy=0) from SHIFT through the final EMIT handshake. A start_val held through that period is accepted only once the block is back in IDLE.
- Arithmetic: no arithmetic on data. Words pass through bit-exact, W bits, with no saturation or sign extension.
- Reset mid-operation (any state) takes effect on the next posedge:
  - Returns to IDLE and drops resp_val, shift_result, array_finished and feed_zero immediately.
  - Buffer contents are zeroed; a partial matrix is never emitted.
- N=2 boundary: CAPTURE lasts 2 cycles and EMIT handles 2 rows. resp_row is 1 bit wide.

Test Plan:
- Basic drain, N=4, W=16: start pulse at t; col_in = row r value 0x0100*(r+1) in every column, presented in order r=3,2,1,0 during t+2..t+5, resp_rdy=1 -> shift_result high only at t+1; resp rows 0..3 = 0x0100,0x0200,0x0300,0x0400 replicated; resp_val at t+6..t+9.
- Column mapping: during CAPTURE col_in column j = {r,j} encoded as 0x0r0j -> row r of resp_msg has column j = 0x0r0j at bits [j*16 +: 16].
- Backpressure: resp_rdy low for 5 cycles on row 1, then high -> resp_msg/resp_row frozen at row 1 throughout; all 4 rows delivered in order; start_rdy stays 0 until after row 3 handshake.
- Start during busy: start_val held high continuously -> exactly one start accepted per drain; second shift_result pulse occurs 1 cycle after start_rdy returns high.
- Reset mid-CAPTURE, at cap_cnt=2 -> next cycle IDLE, start_rdy=1, all control outputs 0; the next full drain returns only new data, with no stale buffer rows.
- Control envelope check: array_finished and feed_zero high for exactly N+1 consecutive cycles (SHIFT plus CAPTURE) per drain, and low in IDLE and EMIT.
